pipe_stage_reg: RTL

- Generic, parametrised inter-stage pipeline register for the OpenMIPS 5-stage core.
- Successor to the hand-written per-stage registers. One instance per stage boundary (if_id, id_ex, ex_mem, mem_wb), each with its own payload width and stall-vector index.
- Adds over the fixed-field version: an explicit valid bit, a synchronous flush, bubble/hold/advance state tracking, the delay-slot return flag, and optional stall/bubble counters.

---
 rtl/pipe_pkg.sv | 70 +++++++
 rtl/pipe_stage_reg_if.sv | 31 +++
 rtl/pipe_sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, stage payload structs and action decode for the pipeline registers
package pipe_pkg;

   localparam int   CTRL_STALL_W = 6;
   localparam logic STOP         = 1'b1;
   localparam logic NO_STOP      = 1'b0;

   localparam int IF_IDX     = 0;
   localparam int IF_ID_IDX  = 1;
   localparam int ID_EX_IDX  = 2;
   localparam int EX_MEM_IDX = 3;
   localparam int MEM_WB_IDX = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_id_t;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] inst;
      logic [31:0] link_addr;
   } id_ex_t;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [7:0]  aluop;
      logic [31:0] mem_addr;
      logic [31:0] reg2;
   } ex_mem_t;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
   } mem_wb_t;

   localparam int IF_ID_W  = $bits(if_id_t);
   localparam int ID_EX_W  = $bits(id_ex_t);
   localparam int EX_MEM_W = $bits(ex_mem_t);
   localparam int MEM_WB_W = $bits(mem_wb_t);

   localparam if_id_t  IF_ID_NOP  = '0;
   localparam id_ex_t  ID_EX_NOP  = '0;
   localparam ex_mem_t EX_MEM_NOP = '0;
   localparam mem_wb_t MEM_WB_NOP = '0;

   typedef enum logic [1:0] {
      ACT_ADVANCE = 2'd0,
      ACT_BUBBLE  = 2'd1,
      ACT_HOLD    = 2'd2,
      ACT_FLUSH   = 2'd3
   } stage_act_e;

   // Flush beats any stall; the illegal (here=0, down=1) case falls through to advance.
   function automatic stage_act_e decode_act(logic flush, logic s_here, logic s_down);
      if (flush)              return ACT_FLUSH;
      if (s_here && !s_down)  return ACT_BUBBLE;
      if (!s_here)            return ACT_ADVANCE;
      return ACT_HOLD;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream signal bundle of one pipeline stage register
interface pipe_stage_reg_if #(
   parameter int PAYLOAD_W = 160,
   parameter int STALL_W   = 6,
   parameter int CNT_W     = 16
);
   logic [STALL_W-1:0]   stall;
   logic                 flush;
   logic                 in_valid;
   logic [PAYLOAD_W-1:0] in_payload;
   logic                 in_is_in_delayslot;
   logic                 in_next_in_delayslot;
   logic                 out_valid;
   logic [PAYLOAD_W-1:0] out_payload;
   logic                 out_is_in_delayslot;
   logic                 next_in_delayslot_o;
   logic [CNT_W-1:0]     stall_cnt;
   logic [CNT_W-1:0]     bubble_cnt;

   modport master (
      output stall, flush, in_valid, in_payload, in_is_in_delayslot, in_next_in_delayslot,
      input  out_valid, out_payload, out_is_in_delayslot, next_in_delayslot_o,
             stall_cnt, bubble_cnt
   );

   modport slave (
      input  stall, flush, in_valid, in_payload, in_is_in_delayslot, in_next_in_delayslot,
      output out_valid, out_payload, out_is_in_delayslot, next_in_delayslot_o,
             stall_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - enable-driven up counter that sticks at all-ones
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage register with valid, flush, bubble/hold and delay-slot return flag
// Optional hold/bubble counters are built when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                   PAYLOAD_W   = 160,
   parameter int                   STALL_W     = CTRL_STALL_W,
   parameter int                   STAGE_IDX   = ID_EX_IDX,
   parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
   parameter int                   CNT_W       = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_stage_reg_if.slave   bus
);
   if (STAGE_IDX < 0 || STAGE_IDX >= STALL_W || PAYLOAD_W < 1) begin : g_bad_cfg
      $fatal(1, "pipe_stage_reg: STAGE_IDX out of stall range or PAYLOAD_W < 1");
   end

   logic       s_here, s_down;
   stage_act_e act;

   assign s_here = bus.stall[STAGE_IDX];
   if (STAGE_IDX + 1 < STALL_W) begin : g_down
      assign s_down = bus.stall[STAGE_IDX+1];
   end else begin : g_no_down
      assign s_down = 1'b0;
   end

   assign act = decode_act(bus.flush, s_here, s_down);

   logic                 valid_q, valid_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;
   logic                 ds_q, ds_d;
   logic                 nds_q, nds_d;

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      ds_d      = ds_q;
      nds_d     = nds_q;
      unique case (act)
         ACT_FLUSH: begin
            valid_d   = 1'b0;
            payload_d = NOP_PAYLOAD;
            ds_d      = 1'b0;
            nds_d     = 1'b0;
         end
         // A branch stalled in decode must keep its delay-slot mark, so nds is not touched.
         ACT_BUBBLE: begin
            valid_d   = 1'b0;
            payload_d = NOP_PAYLOAD;
            ds_d      = 1'b0;
         end
         ACT_ADVANCE: begin
            valid_d   = bus.in_valid;
            payload_d = bus.in_payload;
            ds_d      = bus.in_is_in_delayslot;
            nds_d     = bus.in_next_in_delayslot;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         payload_q <= NOP_PAYLOAD;
         ds_q      <= 1'b0;
         nds_q     <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
         ds_q      <= ds_d;
         nds_q     <= nds_d;
      end
   end

   assign bus.out_valid           = valid_q;
   assign bus.out_payload         = payload_q;
   assign bus.out_is_in_delayslot = ds_q;
   assign bus.next_in_delayslot_o = nds_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (act == ACT_HOLD),
      .cnt_o (bus.stall_cnt)
   );
   pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (act == ACT_BUBBLE),
      .cnt_o (bus.bubble_cnt)
   );
`else
   assign bus.stall_cnt  = {CNT_W{1'b0}};
   assign bus.bubble_cnt = {CNT_W{1'b0}};
`endif

   // Ctrl never lets a stage run while the stage below it is stopped.
   a_no_run_into_stop: assert property (@(posedge clk) disable iff (rst) !(!s_here && s_down));

endmodule
